// File: rtl/gerador_eco_if.sv
// Echo-emulator signal bundle: trigger/distance request and the emulated sensor responses.
interface gerador_eco_if;
  logic        trigger;
  logic [11:0] distancia_bcd;
  logic        echo;
  logic        ocupado;
  logic        pronto;
  logic        erro;

  modport master (
    output trigger, distancia_bcd,
    input  echo, ocupado, pronto, erro
  );

  modport slave (
    input  trigger, distancia_bcd,
    output echo, ocupado, pronto, erro
  );
endinterface

// File: rtl/gerador_eco.sv
// HC-SR04 echo emulator: qualifies a trigger, waits a fixed acoustic delay, then
// holds echo high for distance x TICKS_PER_CM cycles, counting a latched BCD value down.
module gerador_eco #(
  parameter int unsigned TICKS_PER_CM = 2941,
  parameter int unsigned TRIG_MIN     = 500,
  parameter int unsigned ECHO_DELAY   = 100
) (
  input  logic         clock,
  input  logic         reset,
  gerador_eco_if.slave bus
);

  localparam int unsigned TRIG_W = $clog2(TRIG_MIN + 1);
  localparam int unsigned DLY_W  = (ECHO_DELAY > 1) ? $clog2(ECHO_DELAY) : 1;
  localparam int unsigned TICK_W = (TICKS_PER_CM > 1) ? $clog2(TICKS_PER_CM) : 1;

  localparam logic [TRIG_W-1:0] TRIG_SAT  = TRIG_W'(TRIG_MIN);
  localparam logic [DLY_W-1:0]  DLY_LAST  = DLY_W'(ECHO_DELAY - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_CM - 1);

  typedef enum logic [2:0] {
    INICIAL,
    MEDE_TRIGGER,
    ATRASO,
    ECO,
    FIM
  } state_t;

  state_t              state_q,    state_d;
  logic [TRIG_W-1:0]   trig_cnt_q, trig_cnt_d;
  logic [DLY_W-1:0]    dly_cnt_q,  dly_cnt_d;
  logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic [11:0]         bcd_q,      bcd_d;
  logic                invalido_q, invalido_d;
  logic                echo_q, ocupado_q, pronto_q, erro_q;

  function automatic logic bcd_invalido(input logic [11:0] b);
    return (b[11:8] > 4'd9) || (b[7:4] > 4'd9) || (b[3:0] > 4'd9);
  endfunction

  // Decrement by one with digit borrow; only called on a non-zero value.
  function automatic logic [11:0] bcd_dec(input logic [11:0] b);
    logic [3:0] h, t, u;
    h = b[11:8];
    t = b[7:4];
    u = b[3:0];
    if (u != 4'd0) begin
      u = u - 4'd1;
    end else begin
      u = 4'd9;
      if (t != 4'd0) begin
        t = t - 4'd1;
      end else begin
        t = 4'd9;
        h = h - 4'd1;
      end
    end
    return {h, t, u};
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= INICIAL;
      trig_cnt_q <= '0;
      dly_cnt_q  <= '0;
      tick_cnt_q <= '0;
      bcd_q      <= '0;
      invalido_q <= 1'b0;
      echo_q     <= 1'b0;
      ocupado_q  <= 1'b0;
      pronto_q   <= 1'b0;
      erro_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      trig_cnt_q <= trig_cnt_d;
      dly_cnt_q  <= dly_cnt_d;
      tick_cnt_q <= tick_cnt_d;
      bcd_q      <= bcd_d;
      invalido_q <= invalido_d;
      echo_q     <= (state_d == ECO);
      ocupado_q  <= (state_d == ATRASO) || (state_d == ECO) || (state_d == FIM);
      pronto_q   <= (state_d == FIM);
      erro_q     <= (state_d == FIM) && invalido_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    trig_cnt_d = trig_cnt_q;
    dly_cnt_d  = dly_cnt_q;
    tick_cnt_d = tick_cnt_q;
    bcd_d      = bcd_q;
    invalido_d = invalido_q;

    unique case (state_q)
      INICIAL: begin
        // The sample that leaves idle already counts as one high cycle.
        trig_cnt_d = '0;
        if (bus.trigger) begin
          state_d    = MEDE_TRIGGER;
          trig_cnt_d = TRIG_W'(1);
        end
      end

      MEDE_TRIGGER: begin
        if (bus.trigger) begin
          if (trig_cnt_q < TRIG_SAT) trig_cnt_d = trig_cnt_q + TRIG_W'(1);
        end else if (trig_cnt_q >= TRIG_SAT) begin
          state_d    = ATRASO;
          dly_cnt_d  = '0;
          bcd_d      = bus.distancia_bcd;
          invalido_d = bcd_invalido(bus.distancia_bcd);
        end else begin
          state_d = INICIAL;
        end
      end

      ATRASO: begin
        if (dly_cnt_q == DLY_LAST) begin
          tick_cnt_d = '0;
          if (invalido_q || (bcd_q == 12'h000)) state_d = FIM;
          else                                  state_d = ECO;
        end else begin
          dly_cnt_d = dly_cnt_q + DLY_W'(1);
        end
      end

      ECO: begin
        if (tick_cnt_q == TICK_LAST) begin
          tick_cnt_d = '0;
          bcd_d      = bcd_dec(bcd_q);
          if (bcd_q == 12'h001) state_d = FIM;
        end else begin
          tick_cnt_d = tick_cnt_q + TICK_W'(1);
        end
      end

      FIM: state_d = INICIAL;

      default: state_d = INICIAL;
    endcase
  end

  assign bus.echo    = echo_q;
  assign bus.ocupado = ocupado_q;
  assign bus.pronto  = pronto_q;
  assign bus.erro    = erro_q;

endmodule

// File: tb/tb_gerador_eco.sv
// Directed bench for gerador_eco with TICKS_PER_CM=4, TRIG_MIN=3, ECHO_DELAY=2.
module tb_gerador_eco;

  logic clock = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  gerador_eco_if bus ();

  gerador_eco #(
    .TICKS_PER_CM (4),
    .TRIG_MIN     (3),
    .ECHO_DELAY   (2)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          ncyc;
    logic [11:0] bcd;
    int          dly;
    int          width;
    int          pk;
    int          np;
    int          ne;
    int          oc;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nome, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nome, got, exp);
    end
  endtask

  // k = 0 is the edge that samples trigger low (edge A); samples are taken 1 time unit after each edge.
  task automatic run_meas(input int ncyc, input logic [11:0] bcd, input int limit, input bit mexe,
                          output int dly, output int width, output int pk,
                          output int np, output int ne, output int oc);
    dly = -1; width = 0; pk = -1; np = 0; ne = 0; oc = 0;
    bus.distancia_bcd = bcd;
    bus.trigger       = 1'b1;
    repeat (ncyc) begin
      @(posedge clock); #1;
    end
    bus.trigger = 1'b0;
    for (int k = 0; k < limit; k++) begin
      @(posedge clock); #1;
      if (mexe && k == 4) begin
        bus.distancia_bcd = 12'h999;
        bus.trigger       = 1'b1;
      end
      if (mexe && k == 7) bus.trigger = 1'b0;
      if (bus.echo) begin
        if (dly < 0) dly = k;
        width++;
      end
      if (bus.pronto) begin
        if (pk < 0) pk = k;
        np++;
      end
      if (bus.erro) ne++;
      if (bus.ocupado) oc++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dly, width, pk, np, ne, oc, lim;
    int ecount, pcount;

    vecs[0] = '{3, 12'h012,  2,  48,  50, 1, 0,  51};
    vecs[1] = '{2, 12'h012, -1,   0,  -1, 0, 0,   0};
    vecs[2] = '{3, 12'h100,  2, 400, 402, 1, 0, 403};
    vecs[3] = '{3, 12'h000, -1,   0,   2, 1, 0,   3};
    vecs[4] = '{3, 12'h0A5, -1,   0,   2, 1, 1,   3};
    vecs[5] = '{5, 12'h001,  2,   4,   6, 1, 0,   7};
    vecs[6] = '{3, 12'h010,  2,  40,  42, 1, 0,  43};
    vecs[7] = '{3, 12'hF00, -1,   0,   2, 1, 1,   3};

    reset             = 1'b1;
    bus.trigger       = 1'b0;
    bus.distancia_bcd = 12'h000;
    #2;
    chk("reset echo",    int'(bus.echo),    0);
    chk("reset ocupado", int'(bus.ocupado), 0);
    chk("reset pronto",  int'(bus.pronto),  0);
    chk("reset erro",    int'(bus.erro),    0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    repeat (2) begin
      @(posedge clock); #1;
    end

    for (int i = 0; i < 8; i++) begin
      lim = (vecs[i].pk >= 0) ? vecs[i].pk + 6 : 20;
      run_meas(vecs[i].ncyc, vecs[i].bcd, lim, 1'b0, dly, width, pk, np, ne, oc);
      chk($sformatf("v%0d echo_delay", i), dly,   vecs[i].dly);
      chk($sformatf("v%0d echo_width", i), width, vecs[i].width);
      chk($sformatf("v%0d pronto_at",  i), pk,    vecs[i].pk);
      chk($sformatf("v%0d pronto_cnt", i), np,    vecs[i].np);
      chk($sformatf("v%0d erro_cnt",   i), ne,    vecs[i].ne);
      chk($sformatf("v%0d ocupado",    i), oc,    vecs[i].oc);
      repeat (2) begin
        @(posedge clock); #1;
      end
    end

    // Distance change and trigger activity during eco must not disturb the pulse.
    run_meas(3, 12'h003, 30, 1'b1, dly, width, pk, np, ne, oc);
    chk("mexe echo_delay", dly,   2);
    chk("mexe echo_width", width, 12);
    chk("mexe pronto_at",  pk,    14);
    chk("mexe pronto_cnt", np,    1);
    chk("mexe ocupado",    oc,    15);
    chk("mexe erro_cnt",   ne,    0);

    // Reset midway through eco.
    bus.distancia_bcd = 12'h005;
    bus.trigger       = 1'b1;
    repeat (3) begin
      @(posedge clock); #1;
    end
    bus.trigger = 1'b0;
    for (int k = 0; k <= 10; k++) begin
      @(posedge clock); #1;
    end
    chk("pre-reset echo", int'(bus.echo), 1);
    #2 reset = 1'b1;
    #1;
    chk("async reset echo",    int'(bus.echo),    0);
    chk("async reset ocupado", int'(bus.ocupado), 0);
    @(posedge clock); #1;
    reset  = 1'b0;
    ecount = 0;
    pcount = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clock); #1;
      if (bus.echo)   ecount++;
      if (bus.pronto) pcount++;
    end
    chk("post-reset echo",   ecount, 0);
    chk("post-reset pronto", pcount, 0);

    run_meas(3, 12'h002, 16, 1'b0, dly, width, pk, np, ne, oc);
    chk("rec echo_delay", dly,   2);
    chk("rec echo_width", width, 8);
    chk("rec pronto_at",  pk,    10);
    chk("rec pronto_cnt", np,    1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gerador_eco.md
# gerador_eco

Ultrasonic echo emulator: the transmit end of the HC-SR04 echo interface consumed by the cm-counting receiver. It qualifies a trigger pulse, waits a fixed acoustic delay, then drives `echo` high for exactly distance × ticks-per-cm clock cycles. The distance comes from a 3-digit BCD input. The block sits in the sensor-emulation/test path, in place of the physical sensor, feeding the measurement datapath's pulse input.

## Interface

- `TICKS_PER_CM`, default 2941: clock cycles per cm of echo width (50 MHz, 58.82 us/cm); must be ≥ 1.
- `TRIG_MIN`, default 500: minimum trigger high time in cycles (10 us at 50 MHz); must be ≥ 1.
- `ECHO_DELAY`, default 100: cycles between trigger acceptance and the echo rising edge; must be ≥ 1.

- `clock`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high; forces the idle state.
- `trigger`  in  1  trigger request, synchronous to `clock`.
- `distancia_bcd`  in  12  distance in BCD: [11:8] hundreds, [7:4] tens, [3:0] units.
- `echo`  out  1  emulated echo pulse.
- `ocupado`  out  1  high from trigger acceptance until the end of the measurement cycle.
- `pronto`  out  1  single-cycle strobe at the end of each accepted measurement.
- `erro`  out  1  single-cycle strobe, together with `pronto`, when the latched distance has a digit > 9.

## Operation

- Moore FSM with states: `inicial`, `mede_trigger`, `atraso`, `eco`, `fim`.
- `inicial`: clears the trigger counter. Goes to `mede_trigger` when `trigger` = 1.
- `mede_trigger`: increments the trigger counter every cycle while `trigger` = 1. The counter saturates at `TRIG_MIN`.
- On `trigger` = 0 in `mede_trigger`:
  - counter ≥ `TRIG_MIN`: go to `atraso`, and latch `distancia_bcd` into the internal BCD down-counter on the same edge.
  - otherwise: go back to `inicial`, with no outputs asserted (short trigger rejected).
- `atraso`: counts `ECHO_DELAY` cycles. On expiry:
  - latched value = 000 or invalid (any digit > 9): go to `fim`.
  - otherwise: go to `eco`.
- `eco`: a tick counter runs 0..`TICKS_PER_CM`−1. On each wrap, the BCD down-counter decrements by 1 with digit borrow (units 0→9 borrows from tens, tens 0→9 borrows from hundreds). Goes to `fim` on the wrap that brings the value to 000.
- `fim`: lasts one cycle, then goes to `inicial`.
- Outputs, decoded from state and registered flags:
  - `echo` = (state == `eco`).
  - `ocupado` = state ∈ {`atraso`, `eco`, `fim`}.
  - `pronto` = (state == `fim`).
  - `erro` = (state == `fim`) AND invalid flag.
- `trigger` is ignored in `atraso`, `eco` and `fim`. A new measurement needs `trigger` to rise again after the FSM reaches `inicial`. If `trigger` is still high in `inicial`, it starts a fresh `mede_trigger`.
- `distancia_bcd` is sampled only at the acceptance edge. Later changes do not affect the pulse in progress.
- Maximum distance is 999 cm, so the echo width is at most 999 × `TICKS_PER_CM` cycles. The counters are sized so they never overflow.

## Timing

- Reset values: `echo` = 0, `ocupado` = 0, `pronto` = 0, `erro` = 0. State = `inicial`, all counters = 0.
- Reset asserted mid-operation: `echo` and `ocupado` drop immediately (asynchronously). No `pronto` is issued.
- Let edge A be the first rising edge that samples `trigger` = 0 after at least `TRIG_MIN` high cycles. Then:
  - `ocupado` rises after A.
  - `echo` rises exactly `ECHO_DELAY` cycles after A.
  - `echo` stays high for exactly D × `TICKS_PER_CM` cycles, where D is the decimal value of the latched BCD.
  - `pronto` is high for the single cycle immediately after `echo` falls.
  - `ocupado` falls together with `pronto`.
- D = 0 or invalid: `echo` never rises, and `pronto` occurs `ECHO_DELAY` cycles after A.
- Trigger high for exactly `TRIG_MIN` sampled cycles is accepted. `TRIG_MIN` − 1 cycles is rejected.
- Total accepted cycle length = `ECHO_DELAY` + D × `TICKS_PER_CM` + 1 cycles, followed by one cycle in `inicial` before a new trigger can be counted.

## Test plan

The bench uses `TICKS_PER_CM` = 4, `TRIG_MIN` = 3, `ECHO_DELAY` = 2.

- Reset, then 3-cycle trigger with `distancia_bcd` = 0x012 -> `echo` rises 2 cycles after trigger falls and stays high 48 cycles; one `pronto` pulse, `erro` = 0.
- 2-cycle trigger -> no `echo`, no `ocupado`, no `pronto`; FSM back in `inicial`.
- `distancia_bcd` = 0x100 (borrow chain 100→099→…→000) -> `echo` high exactly 400 cycles, then `pronto`.
- `distancia_bcd` = 0x000 -> `echo` stays 0; `pronto` 2 cycles after acceptance. `distancia_bcd` = 0x0A5 -> same timing, with `erro` = 1 alongside `pronto`.
- Change `distancia_bcd` and toggle `trigger` during `eco` -> pulse width unchanged (old value); no re-trigger until after `pronto`.
- Assert `reset` midway through `eco` -> `echo` and `ocupado` low immediately; no `pronto`; next valid trigger produces a normal pulse.
